dmem_rr_arbiter: RTL and testbench
==================================

# dmem_rr_arbiter

Parametrised N-port round-robin arbiter placing N cores in front of one single-port synchronous data memory. It replaces the fixed 10-port memory and its hand-wired testbench muxes. The block adds fair arbitration, optional burst locking with a bounded burst length, a registered read-return path, and a testbench load/dump port that preempts all cores. It sits between the core array and the data memory inside the top level.

## Interface
Parameters:
- N_PORTS, 10, number of core ports (2..16)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_BURST, 8, max consecutive grants to one locked owner before forced rotation (≥1)

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous, active-low reset
- req  in  N_PORTS  per-port access request
- we  in  N_PORTS  per-port write enable (valid with req)
- lock  in  N_PORTS  per-port burst-lock request (valid with req)
- addr  in  N_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_PORTS*DATA_W  per-port write data, same packing
- gnt  out  N_PORTS  one-hot grant, combinational in the request cycle
- rvalid  out  N_PORTS  one-hot read-return strobe
- rdata  out  DATA_W  read data, broadcast, qualified by rvalid
- tb_en  in  1  testbench owns the memory
- tb_we  in  1  testbench write enable
- tb_addr  in  ADDR_W  testbench address
- tb_wdata  in  DATA_W  testbench write data
- tb_rdata  out  DATA_W  testbench read data, one cycle after tb address
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one-cycle synchronous latency

## Operation
- **Testbench mode (tb_en=1).** gnt=0 and cores stall. mem_* is driven from tb_* and tb_rdata=mem_rdata. The burst counter and owner are cleared; the RR pointer holds.
- **Arbitration (tb_en=0).**
  - Search starts at the RR pointer ptr and proceeds upward with wrap (ptr, ptr+1, …, N_PORTS-1, 0, …). The first port with req=1 wins.
  - If a locked owner exists and still asserts req, it wins regardless of ptr, except in the forced-rotation case below.
- **Locking and bursts.**
  - A granted port with lock=1 becomes owner; the burst counter increments on each owner grant.
  - Counter = MAX_BURST and another port requests: the owner is skipped for one arbitration and ownership is released.
  - Counter = MAX_BURST and no other port requests: the owner continues and the counter restarts at 1.
  - Owner drops req or lock: ownership is released immediately, that cycle.
- **Pointer update.**
  - After an unlocked grant to port i, ptr ← (i+1) mod N_PORTS.
  - ptr holds while an owner is granted.
  - ptr holds when no grant occurs.
- **Memory drive.** The granted port's we/addr/wdata drive mem_*. With no grant, mem_we=0 and mem_addr/mem_wdata hold their last values.
- **Read return.**
  - A read grant registers a one-hot return tag.
  - Next cycle: rvalid[tag]=1 and rdata=mem_rdata. This happens even if tb_en rose in between.
  - Writes never produce rvalid.
- **Throughput.** One access per cycle total; back-to-back grants to the same port are allowed.

## Timing
- **Reset** (RESET=0 at a clk edge):
  - Registered state: ptr=0, owner cleared, burst counter=0, return tag=0.
  - Outputs: rvalid=0, rdata=0, tb_rdata=0.
  - While RESET=0, gnt=0 and mem_we=0.
  - An in-flight read is dropped: no rvalid after reset.
- **Grant latency:** 0 cycles. req at cycle t gives gnt at cycle t; the memory write is committed at the t→t+1 edge.
- **Read latency:** gnt with we=0 at cycle t gives rvalid and rdata at cycle t+1.
- **Requester behaviour:** a requester holds req, addr, wdata, and we until it sees gnt high.
- **Preemption:** tb_en rising at cycle t preempts any grant in cycle t; there is no partial access.
- **Simultaneous events:**
  - Owner burst expiry coinciding with owner lock drop counts as a release.
  - Forced rotation sets ptr to owner+1 before the search.
- **Width rules:** the burst counter is $clog2(MAX_BURST+1) bits; ptr is $clog2(N_PORTS) bits, wrapping at N_PORTS-1 (not a power of 2 in general).

## Structure
- Shared package dmem_pkg: default ADDR_W/DATA_W, helper function for the next-index wrap, and the packed-port slicing helper.
- Sub-module rr_pick: combinational N-way rotating priority encoder (inputs req, ptr; outputs one-hot grant and valid). It is reusable by the future instruction-memory arbiter.
- Top of this block: owner/burst registers, ptr register, return-tag register, tb muxing.

## Test plan
- **Reset, then all 10 ports request reads continuously** -> grants rotate 0,1,…,9,0 one per cycle; each rvalid[i] follows gnt[i] by exactly one cycle with the correct memory word.
- **Port 3 locked burst, MAX_BURST=8, port 5 also requesting** -> port 3 granted 8 consecutive cycles, then port 5 once, then port 3 reacquires on its next turn.
- **Port 3 locked and alone, 20 cycles** -> granted all 20 cycles; no gap at the counter restart.
- **tb_en=1, write 0xA5A5 to address 0x0040, then read it back** -> no core gnt during tb_en; tb_rdata=0xA5A5 the next cycle. A core 7 read of 0x0040 after tb_en falls returns 0xA5A5.
- **Core 2 read granted at cycle t, tb_en rising at t+1** -> rvalid[2]=1 at t+1 with valid data; no core gnt from t+1.
- **RESET low mid-burst with a read outstanding** -> no rvalid after the reset edge; after reset, ptr=0, so port 0 wins when ports 0 and 6 both request.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and index helpers.
package dmem_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;

  // Increment with wrap at n-1; n need not be a power of two.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way rotating priority encoder: first requester at or above ptr_i wins,
// searching upward with wrap.
module rr_pick #(
  parameter int unsigned N    = 10,
  parameter int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic            valid_o
);

  logic [PtrW:0] pos;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (pos >= (PtrW + 1)'(N)) begin
        pos = pos - (PtrW + 1)'(N);
      end
      if (!valid_o && req_i[pos[PtrW-1:0]]) begin
        gnt_o[pos[PtrW-1:0]] = 1'b1;
        valid_o              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// N-port round-robin arbiter with bounded burst locking in front of one single-port
// synchronous data memory; a testbench port preempts all cores.
module dmem_rr_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned N_PORTS   = 10,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          we,
  input  logic [N_PORTS-1:0]          lock,
  input  logic [N_PORTS*ADDR_W-1:0]   addr,
  input  logic [N_PORTS*DATA_W-1:0]   wdata,
  output logic [N_PORTS-1:0]          gnt,
  output logic [N_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  input  logic                        tb_en,
  input  logic                        tb_we,
  input  logic [ADDR_W-1:0]           tb_addr,
  input  logic [DATA_W-1:0]           tb_wdata,
  output logic [DATA_W-1:0]           tb_rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned PtrW   = $clog2(N_PORTS);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  logic [PtrW-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic               owner_vld_q, owner_vld_d;
  logic [BurstW-1:0]  burst_q, burst_d;
  logic [N_PORTS-1:0] rtag_q, rtag_d;
  logic               tb_rd_q;
  logic [ADDR_W-1:0]  maddr_q;
  logic [DATA_W-1:0]  mwdata_q;

  logic [ADDR_W-1:0]  addr_lane  [N_PORTS];
  logic [DATA_W-1:0]  wdata_lane [N_PORTS];

  logic [N_PORTS-1:0] pick_gnt;
  logic [PtrW-1:0]    pick_idx, search_ptr, win_idx;
  logic               pick_valid, owner_hold, burst_full, others_req, forced;
  logic               owner_win, win_valid;

  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      addr_lane[i]  = addr[lane_lsb(i, ADDR_W) +: ADDR_W];
      wdata_lane[i] = wdata[lane_lsb(i, DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    others_req = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (PtrW'(i) != owner_q && req[i]) begin
        others_req = 1'b1;
      end
    end
  end

  assign owner_hold = owner_vld_q & req[owner_q] & lock[owner_q];
  assign burst_full = (burst_q == BurstW'(MAX_BURST));
  // An expired burst yields exactly one arbitration to the others, searched from owner+1.
  assign forced     = owner_hold & burst_full & others_req;
  assign owner_win  = owner_hold & ~forced;
  assign search_ptr = forced ? PtrW'(wrap_inc(32'(owner_q), N_PORTS)) : ptr_q;

  rr_pick #(
    .N    (N_PORTS),
    .PtrW (PtrW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (search_ptr),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PtrW'(i);
      end
    end
  end

  assign win_valid = RESET & ~tb_en & (owner_win | pick_valid);
  assign win_idx   = owner_win ? owner_q : pick_idx;

  always_comb begin
    gnt = '0;
    if (win_valid) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = maddr_q;
    mem_wdata = mwdata_q;
    if (tb_en) begin
      mem_we    = tb_we & RESET;
      mem_addr  = tb_addr;
      mem_wdata = tb_wdata;
    end else if (win_valid) begin
      mem_we    = we[win_idx];
      mem_addr  = addr_lane[win_idx];
      mem_wdata = wdata_lane[win_idx];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    rtag_d      = '0;
    if (win_valid && !we[win_idx]) begin
      rtag_d = gnt;
    end
    if (tb_en || !win_valid) begin
      owner_vld_d = 1'b0;
      burst_d     = '0;
    end else if (owner_win) begin
      burst_d = burst_full ? BurstW'(1) : burst_q + BurstW'(1);
    end else if (lock[win_idx]) begin
      owner_vld_d = 1'b1;
      owner_d     = win_idx;
      burst_d     = BurstW'(1);
      ptr_d       = search_ptr;
    end else begin
      owner_vld_d = 1'b0;
      burst_d     = '0;
      ptr_d       = PtrW'(wrap_inc(32'(win_idx), N_PORTS));
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      ptr_q       <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      burst_q     <= '0;
      rtag_q      <= '0;
      tb_rd_q     <= 1'b0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      rtag_q      <= rtag_d;
      tb_rd_q     <= tb_en;
      maddr_q     <= mem_addr;
      mwdata_q    <= mem_wdata;
    end
  end

  assign rvalid   = rtag_q;
  assign rdata    = (|rtag_q) ? mem_rdata : '0;
  assign tb_rdata = tb_rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Randomized self-checking bench for dmem_rr_arbiter against a behavioural arbitration model.
module tb_dmem_rr_arbiter;

  localparam int N  = 10;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            RESET;
  logic [N-1:0]    req, we, lock, gnt, rvalid;
  logic [AW-1:0]   addr_a  [N];
  logic [DW-1:0]   wdata_a [N];
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, tb_rdata, tb_wdata, mem_wdata, mem_rdata;
  logic            tb_en, tb_we, mem_we;
  logic [AW-1:0]   tb_addr, mem_addr;

  always #5 clk = ~clk;

  always_comb begin
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = addr_a[i];
      wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  dmem_rr_arbiter #(
    .N_PORTS   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .tb_en     (tb_en),
    .tb_we     (tb_we),
    .tb_addr   (tb_addr),
    .tb_wdata  (tb_wdata),
    .tb_rdata  (tb_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous memory, read-before-write.
  logic [DW-1:0] mem [65536];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state
  int            m_ptr, m_owner, m_burst, m_rport, m_last_g;
  logic [DW-1:0] m_rdata, m_tbdata;
  bit            m_tbr;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] ref_mem [65536];

  int            n_checks, n_errors;
  logic [N-1:0]  s_gnt, s_rvalid, ev;
  logic [DW-1:0] s_rdata, s_tb_rdata;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(output bit forced);
    int  start;
    bit  others;
    start  = m_ptr;
    forced = 1'b0;
    if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1'b1;
      if (m_burst == MB && others) begin
        forced = 1'b1;
        start  = (m_owner + 1) % N;
      end else begin
        return m_owner;
      end
    end
    for (int k = 0; k < N; k++) if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Called just after a rising edge; checks this cycle, then advances the model.
  task automatic cycle();
    bit           forced, held;
    int           g;
    logic [N-1:0] eg, erv;
    g    = model_pick(forced);
    held = (m_owner >= 0) && req[m_owner] && lock[m_owner];
    eg   = '0;
    erv  = '0;
    if (RESET && !tb_en && g >= 0) eg[g] = 1'b1;
    if (m_rport >= 0) erv[m_rport] = 1'b1;
    @(negedge clk);
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata; s_tb_rdata = tb_rdata;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("rvalid", 32'(rvalid), 32'(erv));
    if (m_rport >= 0) check_eq("rdata", 32'(rdata), 32'(m_rdata));
    if (m_tbr) check_eq("tb_rdata", 32'(tb_rdata), 32'(m_tbdata));
    if (!RESET) begin
      check_eq("mem_we_rst", 32'(mem_we), 32'(0));
    end else if (tb_en) begin
      check_eq("mem_we_tb", 32'(mem_we), 32'(tb_we));
      check_eq("mem_addr_tb", 32'(mem_addr), 32'(tb_addr));
      if (tb_we) check_eq("mem_wdata_tb", 32'(mem_wdata), 32'(tb_wdata));
    end else if (g >= 0) begin
      check_eq("mem_we", 32'(mem_we), 32'(we[g]));
      check_eq("mem_addr", 32'(mem_addr), 32'(addr_a[g]));
      if (we[g]) check_eq("mem_wdata", 32'(mem_wdata), 32'(wdata_a[g]));
    end else begin
      check_eq("mem_we_idle", 32'(mem_we), 32'(0));
      check_eq("mem_addr_hold", 32'(mem_addr), 32'(m_last_addr));
    end
    @(posedge clk);
    m_tbr    = 1'b0;
    m_rport  = -1;
    m_last_g = -1;
    if (!RESET) begin
      m_ptr = 0; m_owner = -1; m_burst = 0; m_last_addr = '0;
    end else if (tb_en) begin
      m_owner = -1; m_burst = 0; m_last_addr = tb_addr;
      if (tb_we) ref_mem[tb_addr] = tb_wdata;
      else begin m_tbr = 1'b1; m_tbdata = ref_mem[tb_addr]; end
    end else if (g >= 0) begin
      m_last_g    = g;
      m_last_addr = addr_a[g];
      if (we[g]) ref_mem[addr_a[g]] = wdata_a[g];
      else begin m_rport = g; m_rdata = ref_mem[addr_a[g]]; end
      if (held && !forced) begin
        m_burst = (m_burst == MB) ? 1 : m_burst + 1;
      end else if (lock[g]) begin
        if (forced) m_ptr = (m_owner + 1) % N;
        m_owner = g; m_burst = 1;
      end else begin
        m_owner = -1; m_burst = 0; m_ptr = (g + 1) % N;
      end
    end else begin
      m_owner = -1; m_burst = 0;
    end
    #1;
  endtask

  task automatic do_reset(int n);
    RESET = 1'b0;
    repeat (n) cycle();
    RESET = 1'b1;
    check_eq("rst_rvalid", 32'(rvalid), 32'(0));
    check_eq("rst_rdata", 32'(rdata), 32'(0));
    check_eq("rst_tb_rdata", 32'(tb_rdata), 32'(0));
  endtask

  task automatic new_req(int i);
    req[i]     = 1'b1;
    we[i]      = ($urandom_range(0, 2) == 0);
    lock[i]    = ($urandom_range(0, 3) == 0);
    addr_a[i]  = AW'($urandom_range(0, 255));
    wdata_a[i] = DW'($urandom);
  endtask

  task automatic clear_ports();
    req = '0; we = '0; lock = '0;
  endtask

  task automatic expect_port(string tag, int p);
    ev = '0;
    ev[p] = 1'b1;
    check_eq(tag, 32'(s_gnt), 32'(ev));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_ptr = 0; m_owner = -1; m_burst = 0; m_rport = -1; m_last_g = -1; m_tbr = 1'b0;
    m_last_addr = '0;
    RESET = 1'b0; tb_en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    clear_ports();
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end
    repeat (2) @(posedge clk);
    #1;

    // Reset with every port requesting
    req = '1;
    do_reset(2);

    // Preload through the testbench port while all cores wait on reads
    for (int i = 0; i < N; i++) addr_a[i] = AW'($urandom_range(0, 255));
    tb_en = 1'b1; tb_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      tb_addr = AW'(a); tb_wdata = DW'($urandom);
      cycle();
    end
    tb_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tb_addr = AW'($urandom_range(0, 255));
      cycle();
    end
    tb_en = 1'b0;

    // All ports reading continuously: strict rotation from port 0
    for (int k = 0; k < 20; k++) begin
      cycle();
      expect_port("rr_seq", k % N);
      if (m_last_g >= 0) addr_a[m_last_g] = AW'($urandom_range(0, 255));
    end
    clear_ports();
    cycle();

    // Port 3 locked burst with port 5 competing
    do_reset(1);
    req[3] = 1'b1; lock[3] = 1'b1; req[5] = 1'b1;
    for (int k = 0; k < 27; k++) begin
      cycle();
      expect_port("burst_seq", (k % 9 == 8) ? 5 : 3);
      if (m_last_g >= 0) addr_a[m_last_g] = AW'($urandom_range(0, 255));
    end
    clear_ports();
    cycle();

    // Port 3 locked and alone: no gap at counter restart
    req[3] = 1'b1; lock[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      expect_port("burst_alone", 3);
    end
    clear_ports();
    cycle();

    // Testbench write/readback, then core 7 reads the same word
    req[7] = 1'b1; addr_a[7] = 16'h0040;
    tb_en = 1'b1; tb_we = 1'b1; tb_addr = 16'h0040; tb_wdata = 16'hA5A5;
    cycle();
    check_eq("tb_wr_nognt", 32'(s_gnt), 32'(0));
    tb_we = 1'b0;
    cycle();
    check_eq("tb_rd_nognt", 32'(s_gnt), 32'(0));
    tb_en = 1'b0;
    cycle();
    check_eq("tb_readback", 32'(s_tb_rdata), 32'h0000A5A5);
    expect_port("core7_gnt", 7);
    clear_ports();
    cycle();
    check_eq("core7_rvalid", 32'(s_rvalid), 32'h80);
    check_eq("core7_rdata", 32'(s_rdata), 32'h0000A5A5);

    // Read granted at t, tb_en rising at t+1
    req[2] = 1'b1; addr_a[2] = AW'($urandom_range(0, 255));
    cycle();
    expect_port("core2_gnt", 2);
    req[2] = 1'b0; req[4] = 1'b1;
    tb_en = 1'b1; tb_addr = AW'($urandom_range(0, 255));
    cycle();
    check_eq("preempt_rvalid", 32'(s_rvalid), 32'h4);
    check_eq("preempt_nognt", 32'(s_gnt), 32'(0));
    cycle();
    check_eq("preempt_nognt2", 32'(s_gnt), 32'(0));
    tb_en = 1'b0;
    cycle();
    expect_port("core4_after_tb", 4);
    clear_ports();
    cycle();

    // Reset mid-burst with a read outstanding
    req[3] = 1'b1; lock[3] = 1'b1;
    repeat (3) cycle();
    do_reset(1);
    clear_ports();
    req[0] = 1'b1; req[6] = 1'b1;
    cycle();
    expect_port("post_rst_ptr0", 0);
    clear_ports();
    cycle();

    // Randomized traffic with occasional testbench preemption
    for (int k = 0; k < 800; k++) begin
      cycle();
      if (tb_en) begin
        if ($urandom_range(0, 1) == 0) tb_en = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        tb_en = 1'b1;
      end
      tb_we    = ($urandom_range(0, 1) == 0);
      tb_addr  = AW'($urandom_range(0, 255));
      tb_wdata = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (m_last_g == i) begin
          if (lock[i] && $urandom_range(0, 5) != 0) begin
            we[i] = ($urandom_range(0, 2) == 0);
            addr_a[i] = AW'($urandom_range(0, 255));
            wdata_a[i] = DW'($urandom);
          end else if ($urandom_range(0, 1) == 0) begin
            new_req(i);
          end else begin
            req[i] = 1'b0; lock[i] = 1'b0;
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (lock[i] && $urandom_range(0, 15) == 0) begin
          lock[i] = 1'b0;
        end
      end
    end
    clear_ports();
    tb_en = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
